// File: rtl/l2_pkg.sv
// l2_pkg: command encodings, FSM states and default widths shared by the L2 request responder.
package l2_pkg;
    localparam int L2_ADDR_W = 26;
    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_SERVICE, ST_RESPOND} state_e;
endpackage

// File: rtl/req_fifo.sv
// req_fifo: synchronous request buffer; a push into a full FIFO is taken when a pop frees a slot at the same edge.
module req_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/l2_request_responder.sv
// l2_request_responder: buffers L1 read/write requests, services each after a fixed latency,
// presents completions on a ready/valid port and keeps saturating statistics.
module l2_request_responder
    import l2_pkg::*;
#(
    parameter int ADDR_W     = L2_ADDR_W,
    parameter int FIFO_DEPTH = 8,
    parameter int LATENCY    = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    cmd_in,
    input  logic [ADDR_W-1:0]             add_in,
    input  logic                          clear,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_cmd,
    output logic [ADDR_W-1:0]             rsp_add,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [CNT_W-1:0]              rd_cnt,
    output logic [CNT_W-1:0]              wr_cnt,
    output logic [CNT_W-1:0]              drop_cnt,
    output logic [CNT_W-1:0]              illegal_cnt
);
    localparam int TW = $clog2(LATENCY + 1);
    localparam int DW = 2 + ADDR_W;
    state_e           r_state;
    state_e           w_state_nx;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nx;
    logic [DW-1:0]    r_rsp;
    logic [DW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_is_req;
    logic             w_accept;
    logic             w_drop;
    logic             r_ovf;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_ill_cnt;
    assign w_is_req = (cmd_in == CMD_READ) || (cmd_in == CMD_WRITE);
    assign w_accept = w_is_req && (!w_full || w_pop);
    assign w_drop   = w_is_req && w_full && !w_pop;
    req_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_is_req),
        .i_pop   (w_pop),
        .i_data  ({cmd_in, add_in}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );
    // A completed handshake with work queued reloads straight into SERVICE, avoiding an IDLE bubble.
    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_pop      = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) begin
                w_pop      = 1'b1;
                w_state_nx = ST_SERVICE;
                w_timer_nx = TW'(LATENCY - 1);
            end
            ST_SERVICE: if (r_timer == '0) w_state_nx = ST_RESPOND;
                        else w_timer_nx = r_timer - 1'b1;
            ST_RESPOND: if (rsp_ready) begin
                w_pop      = !w_empty;
                w_state_nx = w_empty ? ST_IDLE : ST_SERVICE;
                w_timer_nx = TW'(LATENCY - 1);
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_rsp   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            if (w_pop) r_rsp <= w_head;
        end
    end
    // Statistics saturate at all-ones; clear overrides any event in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_drop_cnt <= '0;
            r_ill_cnt  <= '0;
            r_ovf      <= 1'b0;
        end else if (clear) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_drop_cnt <= '0;
            r_ill_cnt  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_rd_cnt   <= r_rd_cnt + CNT_W'(w_accept && cmd_in == CMD_READ && !(&r_rd_cnt));
            r_wr_cnt   <= r_wr_cnt + CNT_W'(w_accept && cmd_in == CMD_WRITE && !(&r_wr_cnt));
            r_drop_cnt <= r_drop_cnt + CNT_W'(w_drop && !(&r_drop_cnt));
            r_ill_cnt  <= r_ill_cnt + CNT_W'(cmd_in == CMD_RSVD && !(&r_ill_cnt));
            r_ovf      <= r_ovf || w_drop;
        end
    end
    assign rsp_valid   = r_state == ST_RESPOND;
    assign rsp_cmd     = r_rsp[ADDR_W +: 2];
    assign rsp_add     = r_rsp[ADDR_W-1:0];
    assign busy        = !w_empty || r_state != ST_IDLE;
    assign overflow    = r_ovf;
    assign rd_cnt      = r_rd_cnt;
    assign wr_cnt      = r_wr_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign illegal_cnt = r_ill_cnt;
endmodule

// File: tb/tb_l2_request_responder.sv
// tb_l2_request_responder: directed and random stimulus against a queue/deadline reference model;
// a second instance with 3-bit counters exposes saturation.
module tb_l2_request_responder;
    import l2_pkg::*;
    localparam int AW = 26, DEPTH = 8, LAT = 4, SW = 3;
    typedef logic [AW+1:0] req_t;
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, rsp_ready = 1'b0;
    logic [1:0] cmd_in = 2'b00;
    logic [AW-1:0] add_in = '0;
    logic rsp_valid, busy, overflow, s_rsp_valid, s_busy, s_overflow;
    logic [1:0] rsp_cmd, s_rsp_cmd;
    logic [AW-1:0] rsp_add, s_rsp_add;
    logic [3:0] fifo_count, s_fifo_count;
    logic [31:0] rd_cnt, wr_cnt, drop_cnt, illegal_cnt;
    logic [SW-1:0] s_rd_cnt, s_wr_cnt, s_drop_cnt, s_illegal_cnt;
    l2_request_responder dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .add_in(add_in), .clear(clear),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cmd(rsp_cmd), .rsp_add(rsp_add),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow), .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt), .drop_cnt(drop_cnt), .illegal_cnt(illegal_cnt)
    );
    l2_request_responder #(.CNT_W(SW)) dut_s (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .add_in(add_in), .clear(clear),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_cmd(s_rsp_cmd), .rsp_add(s_rsp_add),
        .busy(s_busy), .fifo_count(s_fifo_count), .overflow(s_overflow), .rd_cnt(s_rd_cnt),
        .wr_cnt(s_wr_cnt), .drop_cnt(s_drop_cnt), .illegal_cnt(s_illegal_cnt)
    );
    always #5 clk = ~clk;
    // reference model: pending queue, the request in service and the edge at which it completes
    req_t   q[$];
    req_t   cur;
    bit     cur_v, ovf;
    int     due, e;
    longint n_rd, n_wr, n_dr, n_il;
    int     tests = 0, fails = 0;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask
    function automatic bit m_valid();
        return cur_v && e >= due;
    endfunction
    function automatic logic [63:0] sat(input longint v);
        return (v > 7) ? 64'd7 : 64'(v);
    endfunction
    task automatic model_reset();
        q.delete();
        cur_v = 0; ovf = 0;
        n_rd = 0; n_wr = 0; n_dr = 0; n_il = 0;
    endtask
    task automatic compare();
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid()));
        chk("s_rsp_valid", 64'(s_rsp_valid), 64'(m_valid()));
        if (m_valid()) begin
            chk("rsp_cmd", 64'(rsp_cmd), 64'(cur[AW +: 2]));
            chk("rsp_add", 64'(rsp_add), 64'(cur[AW-1:0]));
            chk("s_rsp_add", 64'({s_rsp_cmd, s_rsp_add}), 64'(cur));
        end
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("s_fifo_count", 64'(s_fifo_count), 64'(q.size()));
        chk("busy", 64'(busy), 64'(q.size() > 0 || cur_v));
        chk("s_busy", 64'(s_busy), 64'(q.size() > 0 || cur_v));
        chk("overflow", 64'(overflow), 64'(ovf));
        chk("s_overflow", 64'(s_overflow), 64'(ovf));
        chk("rd_cnt", 64'(rd_cnt), 64'(n_rd));
        chk("wr_cnt", 64'(wr_cnt), 64'(n_wr));
        chk("drop_cnt", 64'(drop_cnt), 64'(n_dr));
        chk("illegal_cnt", 64'(illegal_cnt), 64'(n_il));
        chk("s_rd_sat", 64'(s_rd_cnt), sat(n_rd));
        chk("s_wr_sat", 64'(s_wr_cnt), sat(n_wr));
        chk("s_drop_sat", 64'(s_drop_cnt), sat(n_dr));
        chk("s_ill_sat", 64'(s_illegal_cnt), sat(n_il));
    endtask
    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp"}, 64'({rsp_cmd, rsp_add}), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_count"}, 64'(fifo_count), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_cnts"}, 64'(rd_cnt | wr_cnt | drop_cnt | illegal_cnt), 64'd0);
    endtask
    task automatic step(input logic [1:0] c, input logic [AW-1:0] a, input bit rdy, input bit clr);
        bit hs;
        cmd_in = c; add_in = a; rsp_ready = rdy; clear = clr;
        hs = m_valid() && rdy;
        @(posedge clk);
        e++;
        if (hs) cur_v = 0;
        if (!cur_v && q.size() > 0) begin
            cur = q.pop_front();
            cur_v = 1;
            due = e + LAT;
        end
        if (c == CMD_READ || c == CMD_WRITE) begin
            if (q.size() < DEPTH) begin
                q.push_back({c, a});
                if (c == CMD_READ) n_rd++; else n_wr++;
            end else begin
                n_dr++;
                ovf = 1;
            end
        end else if (c == CMD_RSVD) n_il++;
        if (clr) begin
            n_rd = 0; n_wr = 0; n_dr = 0; n_il = 0; ovf = 0;
        end
        #1 compare();
    endtask
    initial begin
        logic [AW-1:0] got[$];
        longint saved;
        int cnt, r;
        bit seen;
        logic [1:0] c;
        e = 0; due = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        // single read, fixed latency
        step(CMD_READ, 26'h0ABCDEF, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step(CMD_IDLE, '0, 1, 0);
            chk("t1_latency", 64'(rsp_valid), 64'(i == 5));
        end
        chk("t1_cmd", 64'(rsp_cmd), 64'(CMD_READ));
        chk("t1_add", 64'(rsp_add), 64'h0ABCDEF);
        chk("t1_rd_cnt", 64'(rd_cnt), 64'd1);
        step(CMD_IDLE, '0, 1, 0);
        chk("t1_busy", 64'(busy), 64'd0);
        // overflow with backpressure, then in-order drain
        for (int i = 1; i <= 10; i++) step(CMD_WRITE, AW'(i), 0, 0);
        chk("t2_count", 64'(fifo_count), 64'd8);
        chk("t2_drop", 64'(drop_cnt), 64'd1);
        chk("t2_ovf", 64'(overflow), 64'd1);
        chk("t2_wr", 64'(wr_cnt), 64'd9);
        for (int i = 0; i < 80 && got.size() < 9; i++) begin
            if (rsp_valid) got.push_back(rsp_add);
            step(CMD_IDLE, '0, 1, 0);
        end
        chk("t2_n_rsp", 64'(got.size()), 64'd9);
        for (int i = 0; i < got.size(); i++) chk("t2_order", 64'(got[i]), 64'(i + 1));
        chk("t2_idle", 64'(busy), 64'd0);
        // full FIFO, handshake and new read on the same edge
        for (int i = 1; i <= 9; i++) step(CMD_WRITE, AW'(16 + i), 0, 0);
        for (int i = 0; i < 10 && !rsp_valid; i++) step(CMD_IDLE, '0, 0, 0);
        saved = n_dr;
        step(CMD_READ, 26'h123, 1, 0);
        chk("t3_drop", 64'(drop_cnt), 64'(saved));
        chk("t3_count", 64'(fifo_count), 64'd8);
        // hold response under backpressure
        for (int i = 0; i < 20 && !rsp_valid; i++) step(CMD_IDLE, '0, 0, 0);
        chk("t4_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            step(CMD_IDLE, '0, 0, 0);
            chk("t4_hold_cmd", 64'(rsp_cmd), 64'(CMD_WRITE));
            chk("t4_hold_add", 64'(rsp_add), 64'd18);
        end
        step(CMD_IDLE, '0, 1, 0);
        for (int i = 1; i <= LAT; i++) begin
            step(CMD_IDLE, '0, 0, 0);
            chk("t4_b2b_latency", 64'(rsp_valid), 64'(i == LAT));
        end
        chk("t4_next_add", 64'(rsp_add), 64'd19);
        for (int i = 0; i < 200 && busy; i++) step(CMD_IDLE, '0, 1, 0);
        chk("t4_drained", 64'(busy), 64'd0);
        // reserved commands and clear
        for (int i = 0; i < 3; i++) step(CMD_RSVD, AW'($urandom), 0, 0);
        chk("t5_illegal", 64'(illegal_cnt), 64'd3);
        step(CMD_WRITE, 26'h2AAAAAA, 0, 0);
        step(CMD_IDLE, '0, 0, 1);
        chk("t5_clr_cnts", 64'(rd_cnt | wr_cnt | drop_cnt | illegal_cnt), 64'd0);
        chk("t5_clr_ovf", 64'(overflow), 64'd0);
        step(CMD_READ, 26'h3000000, 0, 1);
        chk("t5_clear_wins", 64'(rd_cnt), 64'd0);
        seen = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            if (rsp_valid && rsp_add == 26'h2AAAAAA) seen = 1;
            step(CMD_IDLE, '0, 1, 0);
        end
        chk("t5_write_done", 64'(seen), 64'd1);
        // asynchronous reset mid-service
        step(CMD_READ, 26'h155, 1, 0);
        step(CMD_IDLE, '0, 1, 0);
        step(CMD_IDLE, '0, 1, 0);
        #2 rst_n = 1'b0;
        #1 check_zero("t6_async");
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(CMD_IDLE, '0, 1, 0);
            if (rsp_valid) cnt++;
        end
        chk("t6_no_rsp", 64'(cnt), 64'd0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            c = (r < 3) ? CMD_READ : (r < 6) ? CMD_WRITE : (r < 7) ? CMD_RSVD : CMD_IDLE;
            step(c, (c == CMD_IDLE) ? 'x : AW'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 79) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
